// File: rtl/pi_com_spi.sv
// SPI-slave command port: a 4-byte SPI mode-0 frame becomes a bus request to the
// PET arbiter, completion goes back to the host through a 4-phase handshake.
module pi_com_spi (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_sclk,
   input  logic        spi_cs_n,
   input  logic        spi_rx,
   output logic        spi_tx,
   output logic [16:0] pi_addr,
   output logic [7:0]  pi_data_out,
   input  logic [7:0]  pi_data_in,
   output logic        pi_rw_b,
   input  logic        pi_pending_in,
   output logic        pi_pending_out,
   input  logic        pi_done_in,
   output logic        pi_done_out
);

   typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_DONE} state_t;

   // Handshake rule for the host: a frame is only taken while pi_pending_in is high and
   // the port is IDLE; pi_pending_out stays high until pi_done_in, and pi_done_out stays
   // high until the host drops pi_pending_in.

   logic [2:0]  sclk_sync_q, sclk_sync_d;
   logic [2:0]  cs_sync_q, cs_sync_d;
   logic [1:0]  rx_sync_q, rx_sync_d;
   logic [1:0]  pend_sync_q, pend_sync_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic        full_q, full_d;
   logic [6:0]  shift_q, shift_d;
   logic        cmd_rw_q, cmd_rw_d;
   logic        cmd_a16_q, cmd_a16_d;
   logic [7:0]  addr_hi_q, addr_hi_d;
   logic [7:0]  addr_lo_q, addr_lo_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic        spi_tx_q, spi_tx_d;
   state_t      state_q, state_d;
   logic [16:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        rw_q, rw_d;
   logic        pend_out_q, pend_out_d;
   logic        done_out_q, done_out_d;
   logic [7:0]  read_latch_q, read_latch_d;

   logic       sclk_rise, sclk_fall, cs_active, cs_fall, pend_sync, frame_done;
   logic [7:0] frame_data;

   assign sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall  = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign cs_active  = ~cs_sync_q[1];
   assign cs_fall    = ~cs_sync_q[1] & cs_sync_q[2];
   assign pend_sync  = pend_sync_q[1];
   assign frame_data = {shift_q, rx_sync_q[1]};

   always_comb begin
      sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
      cs_sync_d   = {cs_sync_q[1:0], spi_cs_n};
      rx_sync_d   = {rx_sync_q[0], spi_rx};
      pend_sync_d = {pend_sync_q[0], pi_pending_in};
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      full_d      = full_q;
      shift_d     = shift_q;
      cmd_rw_d    = cmd_rw_q;
      cmd_a16_d   = cmd_a16_q;
      addr_hi_d   = addr_hi_q;
      addr_lo_d   = addr_lo_q;
      tx_sh_d     = tx_sh_q;
      spi_tx_d    = spi_tx_q;
      frame_done  = 1'b0;
      if (!cs_active) begin
         bit_cnt_d  = 3'd0;
         byte_cnt_d = 2'd0;
         full_d     = 1'b0;
         spi_tx_d   = 1'b0;
      end else begin
         // MISO: read_latch is presented during byte 0 only, zeros afterwards
         if (cs_fall) begin
            spi_tx_d = read_latch_q[7];
            tx_sh_d  = {read_latch_q[6:0], 1'b0};
         end else if (sclk_fall) begin
            if (byte_cnt_q == 2'd0 && !full_q) begin
               spi_tx_d = tx_sh_q[7];
               tx_sh_d  = {tx_sh_q[6:0], 1'b0};
            end else begin
               spi_tx_d = 1'b0;
            end
         end
         if (sclk_rise && !full_q) begin
            shift_d   = frame_data[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               case (byte_cnt_q)
                  2'd0: begin
                     cmd_rw_d  = frame_data[7];
                     cmd_a16_d = frame_data[0];
                  end
                  2'd1: addr_hi_d = frame_data;
                  2'd2: addr_lo_d = frame_data;
                  default: begin
                     frame_done = 1'b1;
                     full_d     = 1'b1;
                  end
               endcase
               if (byte_cnt_q != 2'd3) byte_cnt_d = byte_cnt_q + 2'd1;
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      rw_d         = rw_q;
      pend_out_d   = pend_out_q;
      done_out_d   = done_out_q;
      read_latch_d = read_latch_q;
      if (!pend_sync) begin
         // host abort wins over a frame finishing in the same cycle
         state_d    = ST_IDLE;
         pend_out_d = 1'b0;
         done_out_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (frame_done) begin
                  addr_d     = {cmd_a16_q, addr_hi_q, addr_lo_q};
                  rw_d       = cmd_rw_q;
                  data_d     = frame_data;
                  pend_out_d = 1'b1;
                  state_d    = ST_PENDING;
               end
            end
            ST_PENDING: begin
               if (pi_done_in) begin
                  if (rw_q) read_latch_d = pi_data_in;
                  pend_out_d = 1'b0;
                  done_out_d = 1'b1;
                  state_d    = ST_DONE;
               end
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_q  <= 3'b000;
         cs_sync_q    <= 3'b111;
         rx_sync_q    <= 2'b00;
         pend_sync_q  <= 2'b00;
         bit_cnt_q    <= 3'd0;
         byte_cnt_q   <= 2'd0;
         full_q       <= 1'b0;
         shift_q      <= 7'd0;
         cmd_rw_q     <= 1'b1;
         cmd_a16_q    <= 1'b0;
         addr_hi_q    <= 8'd0;
         addr_lo_q    <= 8'd0;
         tx_sh_q      <= 8'd0;
         spi_tx_q     <= 1'b0;
         state_q      <= ST_IDLE;
         addr_q       <= 17'd0;
         data_q       <= 8'd0;
         rw_q         <= 1'b1;
         pend_out_q   <= 1'b0;
         done_out_q   <= 1'b0;
         read_latch_q <= 8'd0;
      end else begin
         sclk_sync_q  <= sclk_sync_d;
         cs_sync_q    <= cs_sync_d;
         rx_sync_q    <= rx_sync_d;
         pend_sync_q  <= pend_sync_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         full_q       <= full_d;
         shift_q      <= shift_d;
         cmd_rw_q     <= cmd_rw_d;
         cmd_a16_q    <= cmd_a16_d;
         addr_hi_q    <= addr_hi_d;
         addr_lo_q    <= addr_lo_d;
         tx_sh_q      <= tx_sh_d;
         spi_tx_q     <= spi_tx_d;
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         rw_q         <= rw_d;
         pend_out_q   <= pend_out_d;
         done_out_q   <= done_out_d;
         read_latch_q <= read_latch_d;
      end
   end

   assign spi_tx         = spi_tx_q;
   assign pi_addr        = addr_q;
   assign pi_data_out    = data_q;
   assign pi_rw_b        = rw_q;
   assign pi_pending_out = pend_out_q;
   assign pi_done_out    = done_out_q;

endmodule

// File: tb/tb_pi_com_spi.sv
// Bench for pi_com_spi: table of host frames, hand-written handshake/abort/reset
// sequences, then random traffic against a transaction-level model of the port.
module tb_pi_com_spi;

   logic        clk = 1'b0;
   logic        reset, spi_sclk, spi_cs_n, spi_rx, spi_tx;
   logic [16:0] pi_addr;
   logic [7:0]  pi_data_out, pi_data_in;
   logic        pi_rw_b, pi_pending_in, pi_pending_out, pi_done_in, pi_done_out;

   pi_com_spi dut (
      .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
      .spi_rx(spi_rx), .spi_tx(spi_tx), .pi_addr(pi_addr), .pi_data_out(pi_data_out),
      .pi_data_in(pi_data_in), .pi_rw_b(pi_rw_b), .pi_pending_in(pi_pending_in),
      .pi_pending_out(pi_pending_out), .pi_done_in(pi_done_in), .pi_done_out(pi_done_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [25:0] exp_q[$];

   // transaction-level model: m_state 0 = idle, 1 = request open, 2 = completed
   logic [16:0] m_addr;
   logic [7:0]  m_data, m_latch;
   logic        m_rw, m_pend;
   int          m_state;

   typedef struct {
      logic [31:0] frame;
      logic        pend;
      logic        exp_pend;
      logic [16:0] exp_addr;
      logic        exp_rw;
      logic [7:0]  exp_data;
      logic [7:0]  exp_miso0;
      logic        do_done;
      logic [7:0]  din;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check($sformatf("%s addr", tag), 32'(pi_addr), 32'(m_addr));
      check($sformatf("%s rw_b", tag), 32'(pi_rw_b), 32'(m_rw));
      check($sformatf("%s data_out", tag), 32'(pi_data_out), 32'(m_data));
      check($sformatf("%s pending_out", tag), 32'(pi_pending_out), 32'(m_state == 1));
      check($sformatf("%s done_out", tag), 32'(pi_done_out), 32'(m_state == 2));
      check($sformatf("%s spi_tx idle", tag), 32'(spi_tx), 32'd0);
   endtask

   task automatic model_reset();
      m_addr = '0; m_rw = 1'b1; m_data = '0; m_latch = '0; m_state = 0;
      exp_q.delete();
   endtask

   task automatic set_pend(input logic v);
      @(negedge clk);
      pi_pending_in = v;
      if (!v) begin
         repeat (3) @(negedge clk);
         m_state = 0;
         check("abort pending_out", 32'(pi_pending_out), 32'd0);
         check("abort done_out", 32'(pi_done_out), 32'd0);
         @(negedge clk);
      end else begin
         repeat (4) @(negedge clk);
      end
      m_pend = v;
   endtask

   task automatic do_done(input logic [7:0] d);
      @(negedge clk);
      pi_data_in = d;
      pi_done_in = 1'b1;
      @(negedge clk);
      if (m_state == 1) begin
         if (m_rw) m_latch = d;
         m_state = 2;
      end
      check_outputs("done");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pi_done_in = 1'b0;
      pi_data_in = 8'($urandom);
      repeat (2) @(negedge clk);
      check_outputs("done released");
   endtask

   task automatic spi_xfer(input logic [31:0] frame, input int nbits, input int rst_bit,
                           output logic [31:0] miso, output int lat);
      logic was_pend;
      miso = '0;
      lat = 0;
      was_pend = 1'b0;
      @(negedge clk);
      spi_cs_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         spi_rx = (i < 32) ? frame[31-i] : 1'($urandom);
         if (i == rst_bit) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
         end
         repeat (4) @(negedge clk);
         if (i < 32) miso[31-i] = spi_tx;
         if (i == 31) was_pend = pi_pending_out;
         spi_sclk = 1'b1;
         for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (i == 31 && lat == 0 && pi_pending_out && !was_pend) lat = k;
         end
         spi_sclk = 1'b0;
      end
      repeat (2) @(negedge clk);
      spi_cs_n = 1'b1;
      spi_rx = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic run_frame(input string tag, input logic [31:0] frame, input int nbits,
                            input int rst_bit, output logic [31:0] miso);
      logic [31:0] exp_miso, mask;
      int lat, nb;
      bit acc;
      exp_miso = {m_latch, 24'h0};
      acc = (nbits >= 32) && m_pend && (m_state == 0) && (rst_bit < 0);
      spi_xfer(frame, nbits, rst_bit, miso, lat);
      nb = (nbits > 32) ? 32 : nbits;
      if (rst_bit >= 0 && rst_bit < nb) nb = rst_bit;
      mask = '0;
      for (int j = 0; j < nb; j++) mask[31-j] = 1'b1;
      check($sformatf("%s miso", tag), miso & mask, exp_miso & mask);
      if (rst_bit >= 0) model_reset();
      if (acc) begin
         m_addr  = {frame[24], frame[23:8]};
         m_rw    = frame[31];
         m_data  = frame[7:0];
         m_state = 1;
         exp_q.push_back({m_rw, m_addr, m_data});
         check($sformatf("%s pending latency", tag), (lat >= 1 && lat <= 4) ? 32'd1 : 32'(lat), 32'd1);
         check($sformatf("%s command", tag), 32'({pi_rw_b, pi_addr, pi_data_out}), 32'(exp_q.pop_front()));
      end
      check_outputs(tag);
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] miso;
      int r, nbits;
      reset = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_rx = 1'b0;
      pi_data_in = '0; pi_pending_in = 1'b0; pi_done_in = 1'b0;
      model_reset();
      m_pend = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_outputs("reset");

      // frame, pend, exp_pend, exp_addr, exp_rw, exp_data, exp_miso0, do_done, din
      vecs[0] = '{32'h2B1234A5, 1'b1, 1'b1, 17'h11234, 1'b0, 8'hA5, 8'h00, 1'b1, 8'h99};
      vecs[1] = '{32'hAA55817E, 1'b1, 1'b1, 17'h05581, 1'b1, 8'h7E, 8'h00, 1'b1, 8'hC3};
      vecs[2] = '{32'h80010203, 1'b0, 1'b0, 17'h05581, 1'b1, 8'h7E, 8'hC3, 1'b0, 8'h00};
      vecs[3] = '{32'h0000FF11, 1'b1, 1'b1, 17'h000FF, 1'b0, 8'h11, 8'hC3, 1'b0, 8'h00};
      vecs[4] = '{32'h81FFFF22, 1'b1, 1'b1, 17'h000FF, 1'b0, 8'h11, 8'hC3, 1'b1, 8'h5A};
      vecs[5] = '{32'h7EABCD01, 1'b1, 1'b1, 17'h0ABCD, 1'b0, 8'h01, 8'hC3, 1'b1, 8'h66};
      for (int v = 0; v < 6; v++) begin
         if (m_pend != vecs[v].pend) set_pend(vecs[v].pend);
         run_frame($sformatf("vec%0d", v), vecs[v].frame, 32, -1, miso);
         check($sformatf("vec%0d tbl pending", v), 32'(pi_pending_out), 32'(vecs[v].exp_pend));
         check($sformatf("vec%0d tbl addr", v), 32'(pi_addr), 32'(vecs[v].exp_addr));
         check($sformatf("vec%0d tbl rw", v), 32'(pi_rw_b), 32'(vecs[v].exp_rw));
         check($sformatf("vec%0d tbl data", v), 32'(pi_data_out), 32'(vecs[v].exp_data));
         check($sformatf("vec%0d tbl miso", v), miso, {vecs[v].exp_miso0, 24'h0});
         if (vecs[v].do_done) begin
            do_done(vecs[v].din);
            set_pend(1'b0);
         end
      end

      // completion strobe while idle must not reach the host
      set_pend(1'b1);
      do_done(8'hEE);

      // 12-bit aborted frame, then a clean write
      run_frame("partial", 32'h81234567, 12, -1, miso);
      run_frame("after partial", 32'h010FF03C, 32, -1, miso);
      check("after partial addr", 32'(pi_addr), 32'h10FF0);
      check("after partial data", 32'(pi_data_out), 32'h3C);

      // host abort while pending keeps the decoded command
      set_pend(1'b0);
      check("abort holds addr", 32'(pi_addr), 32'h10FF0);

      // trailing fifth byte ignored; read completion feeds the next frame's MISO
      set_pend(1'b1);
      run_frame("long frame", 32'h80010233, 40, -1, miso);
      do_done(8'h4D);
      set_pend(1'b0);
      set_pend(1'b1);
      run_frame("readback", 32'h00000000, 32, -1, miso);
      check("readback miso", miso, 32'h4D000000);
      set_pend(1'b0);

      // reset in the middle of a frame
      set_pend(1'b1);
      run_frame("midreset", 32'h12345678, 32, 20, miso);
      run_frame("post reset", 32'h01020304, 32, -1, miso);
      check("post reset miso", miso, 32'h00000000);
      set_pend(1'b0);

      for (int it = 0; it < 30; it++) begin
         if (!m_pend && $urandom_range(0, 2) != 0) set_pend(1'b1);
         r = $urandom_range(0, 9);
         nbits = (r == 0) ? $urandom_range(1, 31) : (r == 1) ? 40 : 32;
         run_frame($sformatf("rand%0d", it), $urandom, nbits, -1, miso);
         if ($urandom_range(0, 3) != 0) do_done(8'($urandom));
         if (m_state == 2 || $urandom_range(0, 4) == 0) set_pend(1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
